// File: rtl/iq_pair_fifo.sv
// iq_pair_fifo: reassembles I (channel 0) and Q (channel 1) sample strobes
// from the DDC channelizer into I/Q pairs. The pairs are buffered in a
// show-ahead FIFO with a valid/ready readout port. Channel desync, upstream
// errors and dropped pairs are flagged. The sticky overflow flag is always
// present.
// Optional build macro: IQ_PAIR_STATS_EN enables the saturating
// desync_cnt / overflow_cnt event counters. When it is undefined, both
// ports are tied to zero.
module iq_pair_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] q_data,
  input  logic                    q_valid,
  input  logic [1:0]              in_error,
  output logic signed [WIDTH-1:0] out_i,
  output logic signed [WIDTH-1:0] out_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DEPTH_LOG2:0]     fill_level,
  output logic                    overflow,
  output logic [7:0]              desync_cnt,
  output logic [7:0]              overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {WAIT_I, WAIT_Q} pair_state_t;

  pair_state_t             state, state_nxt;
  logic signed [WIDTH-1:0] i_hold;
  logic                    hold_ld;
  logic                    err_ev;

  logic                    push_p0;
  logic signed [WIDTH-1:0] pair_i_p0, pair_q_p0;

  logic signed [WIDTH-1:0] mem_i [DEPTH];
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]     count, count_after_pop, count_nxt;
  logic                    pop, full, wr_en, drop;
  logic signed [WIDTH-1:0] head_i, head_q;

  // An error on either strobe is one event, however many strobes carry it.
  assign err_ev = (i_valid || q_valid) && (in_error != 2'b00);

  // ---- stage p0: pairing decision on the incoming strobes ----
  // Pairing decode: what to push, whether to latch I, and the next state.
  always_comb begin
    state_nxt = state;
    hold_ld   = 1'b0;
    push_p0   = 1'b0;
    pair_i_p0 = i_data;
    pair_q_p0 = q_data;
    if (err_ev) begin
      state_nxt = WAIT_I;
    end else begin
      case (state)
        WAIT_I: begin
          if (i_valid && q_valid) begin
            push_p0 = 1'b1;
          end else if (i_valid) begin
            hold_ld   = 1'b1;
            state_nxt = WAIT_Q;
          end
        end
        WAIT_Q: begin
          pair_i_p0 = i_hold;
          if (q_valid) begin
            push_p0 = 1'b1;
            if (i_valid) hold_ld = 1'b1;
            else         state_nxt = WAIT_I;
          end else if (i_valid) begin
            hold_ld = 1'b1;
          end
        end
        default: state_nxt = WAIT_I;
      endcase
    end
  end

  // FIFO bookkeeping. A push into a full FIFO is accepted only when the head
  // leaves in the same cycle, so the slot it vacates is reused.
  always_comb begin
    pop             = out_ready && (count != '0);
    full            = (count == FULL_LVL);
    wr_en           = push_p0 && (!full || pop);
    drop            = push_p0 && full && !pop;
    rd_ptr_nxt      = pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
    count_after_pop = count - {{DEPTH_LOG2{1'b0}}, pop};
    count_nxt       = count_after_pop + {{DEPTH_LOG2{1'b0}}, wr_en};
    // If the FIFO drains to nothing before this push, the pushed pair becomes
    // the head directly; otherwise the head comes from storage.
    if (count_after_pop == '0) begin
      head_i = pair_i_p0;
      head_q = pair_q_p0;
    end else begin
      head_i = mem_i[rd_ptr_nxt];
      head_q = mem_q[rd_ptr_nxt];
    end
  end

  // ---- stage p1: registered FIFO state and show-ahead head ----
  // Control state: pairing FSM, pointers, fill, head output, sticky overflow.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= WAIT_I;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (count_nxt != '0) begin
        out_i <= head_i;
        out_q <= head_q;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Data path: I holding register and pair storage (contents need no reset).
  always_ff @(posedge clk_in) begin
    if (hold_ld && !rst) i_hold <= i_data;
    if (wr_en && !rst) begin
      mem_i[wr_ptr] <= pair_i_p0;
      mem_q[wr_ptr] <= pair_q_p0;
    end
  end

  assign fill_level = count;

`ifdef IQ_PAIR_STATS_EN
  logic desync_ev;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  // Lone Q in WAIT_I or lone I in WAIT_Q means a sample was discarded.
  assign desync_ev = err_ev ||
                     ((state == WAIT_I) && q_valid && !i_valid) ||
                     ((state == WAIT_Q) && i_valid && !q_valid);

  // Saturating event counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      desync_cnt   <= 8'd0;
      overflow_cnt <= 8'd0;
    end else begin
      desync_cnt   <= sat_inc(desync_cnt, desync_ev);
      overflow_cnt <= sat_inc(overflow_cnt, drop);
    end
  end
`else
  assign desync_cnt   = 8'd0;
  assign overflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Scoreboard bench for iq_pair_fifo: stimulus pushes hand-computed pairs
// into a queue, and a monitor pops and compares on every accepted output.
module tb_iq_pair_fifo;

`ifdef IQ_PAIR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] i_data = '0;
  logic               i_valid = 1'b0;
  logic signed [31:0] q_data = '0;
  logic               q_valid = 1'b0;
  logic [1:0]         in_error = 2'b00;
  logic signed [31:0] out_i, out_q;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [4:0]         fill_level;
  logic               overflow;
  logic [7:0]         desync_cnt, overflow_cnt;

  typedef struct {logic [31:0] i; logic [31:0] q;} pair_t;
  pair_t exp_q[$];
  pair_t mon_e;
  int checks = 0;
  int errors = 0;

  iq_pair_fifo #(.WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk_in(clk_in), .rst(rst),
    .i_data(i_data), .i_valid(i_valid),
    .q_data(q_data), .q_valid(q_valid),
    .in_error(in_error),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow),
    .desync_cnt(desync_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pair must match the oldest expected pair.
  always @(negedge clk_in) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair got %0h/%0h expected none", out_i, out_q);
      end else begin
        mon_e = exp_q.pop_front();
        check("pair_i", 64'(out_i), 64'(mon_e.i));
        check("pair_q", 64'(out_q), 64'(mon_e.q));
      end
    end
  end

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [31:0] id,
                     input logic qv, input logic [31:0] qd, input logic [1:0] err);
    i_valid = iv; i_data = id; q_valid = qv; q_data = qd; in_error = err;
    @(posedge clk_in); #1;
    i_valid = 1'b0; q_valid = 1'b0; in_error = 2'b00;
  endtask

  task automatic exp_pair(input logic [31:0] i, input logic [31:0] q);
    pair_t p;
    p.i = i; p.q = q;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk_in); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk_in); #1;
      n++;
    end
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_fill"}, 64'(fill_level), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_i", 64'(out_i), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_desync_cnt", 64'(desync_cnt), 64'd0);
    check("rst_overflow_cnt", 64'(overflow_cnt), 64'd0);

    // Alternating strobes, two pairs in order.
    exp_pair(32'h11, 32'h22);
    cyc(1'b1, 32'h11, 1'b0, 32'h0, 2'b00);
    check("alt_no_early_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 32'h0, 1'b1, 32'h22, 2'b00);
    check("alt_valid_after_q1", 64'(out_valid), 64'd1);
    check("alt_fill1", 64'(fill_level), 64'd1);
    exp_pair(32'h33, 32'h44);
    cyc(1'b1, 32'h33, 1'b0, 32'h0, 2'b00);
    cyc(1'b0, 32'h0, 1'b1, 32'h44, 2'b00);
    check("alt_valid_after_q2", 64'(out_valid), 64'd1);
    drain("alt");
    check("alt_desync_cnt", 64'(desync_cnt), 64'd0);
    check("alt_overflow_cnt", 64'(overflow_cnt), 64'd0);

    // Two I strobes in a row: the older I is replaced.
    do_reset();
    exp_pair(32'hB, 32'hC);
    cyc(1'b1, 32'hA, 1'b0, 32'h0, 2'b00);
    cyc(1'b1, 32'hB, 1'b0, 32'h0, 2'b00);
    cyc(1'b0, 32'h0, 1'b1, 32'hC, 2'b00);
    drain("ii_q");
    check("ii_q_desync_cnt", 64'(desync_cnt), STATS ? 64'd1 : 64'd0);

    // Q strobe before any I is discarded.
    do_reset();
    cyc(1'b0, 32'h0, 1'b1, 32'h99, 2'b00);
    check("lone_q_fill", 64'(fill_level), 64'd0);
    exp_pair(32'h1, 32'h2);
    cyc(1'b1, 32'h1, 1'b0, 32'h0, 2'b00);
    cyc(1'b0, 32'h0, 1'b1, 32'h2, 2'b00);
    drain("lone_q");
    check("lone_q_desync_cnt", 64'(desync_cnt), STATS ? 64'd1 : 64'd0);

    // Overflow: 17 pairs into 16 slots with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k < 16) exp_pair(32'h100 + k, 32'h200 + k);
      cyc(1'b1, 32'h100 + k, 1'b1, 32'h200 + k, 2'b00);
    end
    check("ovf_fill_full", 64'(fill_level), 64'd16);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_cnt", 64'(overflow_cnt), STATS ? 64'd1 : 64'd0);
    check("ovf_head_i", 64'(out_i), 64'h100);
    check("ovf_desync_cnt", 64'(desync_cnt), 64'd0);
    // Push while full with a simultaneous pop: accepted.
    out_ready = 1'b1;
    exp_pair(32'h300, 32'h301);
    cyc(1'b1, 32'h300, 1'b1, 32'h301, 2'b00);
    check("full_pushpop_fill", 64'(fill_level), 64'd16);
    check("full_pushpop_cnt", 64'(overflow_cnt), STATS ? 64'd1 : 64'd0);
    drain("ovf");
    check("ovf_still_sticky", 64'(overflow), 64'd1);

    // Upstream error on the Q strobe aborts the pair.
    do_reset();
    cyc(1'b1, 32'h5, 1'b0, 32'h0, 2'b00);
    cyc(1'b0, 32'h0, 1'b1, 32'h6, 2'b01);
    check("err_no_push_fill", 64'(fill_level), 64'd0);
    check("err_no_push_valid", 64'(out_valid), 64'd0);
    check("err_desync_cnt", 64'(desync_cnt), STATS ? 64'd1 : 64'd0);
    exp_pair(32'h7, 32'h8);
    cyc(1'b1, 32'h7, 1'b0, 32'h0, 2'b00);
    cyc(1'b0, 32'h0, 1'b1, 32'h8, 2'b00);
    drain("err_recover");
    // An error on both strobes at once is a single event.
    cyc(1'b1, 32'h9, 1'b1, 32'hA, 2'b10);
    check("err_both_fill", 64'(fill_level), 64'd0);
    check("err_both_desync_cnt", 64'(desync_cnt), STATS ? 64'd2 : 64'd0);

    // Reset mid-operation discards contents; strobes during reset are ignored.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_pair(32'h500 + k, 32'h600 + k);
      cyc(1'b1, 32'h500 + k, 1'b1, 32'h600 + k, 2'b00);
    end
    cyc(1'b0, 32'h0, 1'b1, 32'h77, 2'b00);
    check("mid_fill5", 64'(fill_level), 64'd5);
    check("mid_desync_pre", 64'(desync_cnt), STATS ? 64'd1 : 64'd0);
    rst = 1'b1;
    exp_q.delete();
    i_valid = 1'b1; i_data = 32'hDEAD; q_valid = 1'b1; q_data = 32'hBEEF;
    @(posedge clk_in); #1;
    rst = 1'b0; i_valid = 1'b0; q_valid = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_desync_cnt", 64'(desync_cnt), 64'd0);
    check("mid_rst_overflow_cnt", 64'(overflow_cnt), 64'd0);
    check("mid_rst_out_i", 64'(out_i), 64'd0);
    out_ready = 1'b1;
    @(posedge clk_in); #1;
    check("mid_rst_still_empty", 64'(out_valid), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
